cordic: RTL and testbench



---
 rtl/cordic_if.sv | 24 ++
 rtl/cordic.sv | 150 +++++++++++++++
 tb/tb_cordic.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cordic_if.sv
// rtl/cordic_if.sv - req/ack handshake bundle between a trig client and the cordic unit
interface cordic_if;
  logic               i_req;
  logic signed [19:0] i_theta;
  logic signed [19:0] o_sin;
  logic signed [19:0] o_cos;
  logic               o_ack;

  modport master (
    output i_req,
    output i_theta,
    input  o_sin,
    input  o_cos,
    input  o_ack
  );

  modport slave (
    input  i_req,
    input  i_theta,
    output o_sin,
    output o_cos,
    output o_ack
  );
endinterface

// File: rtl/cordic.sv
// rtl/cordic.sv - iterative rotation-mode CORDIC sin/cos, Q4.16, optional CORDIC_ROUND_EN output rounding
module cordic #(
  parameter int ITER = 16
) (
  input  logic i_clk,
  input  logic i_nrst,
  cordic_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0]         LAST   = 5'(ITER);
  localparam logic signed [23:0] PI_Q   = 24'sd205887;
  localparam logic signed [23:0] HPI_Q  = 24'sd102944;
  // K = 0.607253 in Q16, pre-scaled by 16 for the guard bits
  localparam logic signed [23:0] K_INIT = 24'sd636752;

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic signed [23:0] x, y, z;
  logic               neg;

  logic signed [23:0] th_ext, th_fold;
  logic               fold_neg;
  logic signed [23:0] xs, ys, atan_v;
  logic signed [23:0] x_nxt, y_nxt, z_nxt;
  logic signed [23:0] xr, yr, xr_n, yr_n;
  logic               unused_bits;

  // atan(2^-i) in Q16, scaled by 16 to match the datapath
  function automatic logic signed [23:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 24'sd823552;
      5'd1:    atan_lut = 24'sd486176;
      5'd2:    atan_lut = 24'sd256880;
      5'd3:    atan_lut = 24'sd130400;
      5'd4:    atan_lut = 24'sd65456;
      5'd5:    atan_lut = 24'sd32752;
      5'd6:    atan_lut = 24'sd16384;
      5'd7:    atan_lut = 24'sd8192;
      5'd8:    atan_lut = 24'sd4096;
      5'd9:    atan_lut = 24'sd2048;
      5'd10:   atan_lut = 24'sd1024;
      5'd11:   atan_lut = 24'sd512;
      5'd12:   atan_lut = 24'sd256;
      5'd13:   atan_lut = 24'sd128;
      5'd14:   atan_lut = 24'sd64;
      5'd15:   atan_lut = 24'sd32;
      5'd16:   atan_lut = 24'sd16;
      default: atan_lut = 24'sd0;
    endcase
  endfunction

  // Fold the incoming angle into [-pi/2, +pi/2]; the outer quadrants become a sign flip
  always_comb begin
    th_ext   = {{4{bus.i_theta[19]}}, bus.i_theta};
    th_fold  = th_ext;
    fold_neg = 1'b0;
    if (th_ext > HPI_Q) begin
      th_fold  = th_ext - PI_Q;
      fold_neg = 1'b1;
    end else if (th_ext < -HPI_Q) begin
      th_fold  = th_ext + PI_Q;
      fold_neg = 1'b1;
    end
  end

  // One micro-rotation: direction taken from the sign of the residual angle
  always_comb begin
    xs     = x >>> cnt;
    ys     = y >>> cnt;
    atan_v = atan_lut(cnt);
    if (z[23]) begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + atan_v;
    end else begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - atan_v;
    end
  end

  // Drop the 4 guard bits (truncate or round to nearest), then undo the quadrant fold
  always_comb begin
`ifdef CORDIC_ROUND_EN
    xr = (x + 24'sd8) >>> 4;
    yr = (y + 24'sd8) >>> 4;
`else
    xr = x >>> 4;
    yr = y >>> 4;
`endif
    xr_n = neg ? -xr : xr;
    yr_n = neg ? -yr : yr;
  end

  // Upper bits are sign copies once the result is back in Q4.16 range
  assign unused_bits = ^{xr_n[23:20], yr_n[23:20]};

  // Handshake FSM and iteration datapath
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      x          <= 24'sd0;
      y          <= 24'sd0;
      z          <= 24'sd0;
      neg        <= 1'b0;
      bus.o_sin  <= 20'sd0;
      bus.o_cos  <= 20'sd0;
      bus.o_ack  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            x     <= K_INIT;
            y     <= 24'sd0;
            z     <= th_fold <<< 4;
            neg   <= fold_neg;
            cnt   <= 5'd0;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            bus.o_cos <= xr_n[19:0];
            bus.o_sin <= yr_n[19:0];
            bus.o_ack <= 1'b1;
            state     <= DONE;
          end else begin
            x   <= x_nxt;
            y   <= y_nxt;
            z   <= z_nxt;
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (!bus.i_req) begin
            bus.o_ack <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic.sv
// tb/tb_cordic.sv - scoreboard bench for the cordic sin/cos unit
module tb_cordic;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cordic_if bus ();

  cordic #(.ITER(16)) dut (
    .i_clk  (clk),
    .i_nrst (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    int theta;
    int es;
    int ec;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
    n_checks++;
    if ((obs - exp > tol) || (exp - obs > tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic exp_t model(input int th);
    exp_t e;
    real  a;
    a       = real'(th) / 65536.0;
    e.theta = th;
    e.es    = int'($sin(a) * 65536.0);
    e.ec    = int'($cos(a) * 65536.0);
    return e;
  endfunction

  task automatic do_op(input string tag, input int th, input int hold, input bit toggle, input bit chk_lat);
    int     lat;
    int     unstable;
    longint s, c;
    exp_t   e;
    logic signed [19:0] hs, hc;
    @(negedge clk);
    bus.i_req   = 1'b1;
    bus.i_theta = 20'(th);
    sb.push_back(model(th));
    @(posedge clk);
    lat = 0;
    while (!bus.o_ack && lat < 100) begin
      @(negedge clk);
      if (toggle && lat < 8) begin
        bus.i_req   = 1'($urandom_range(0, 1));
        bus.i_theta = 20'($urandom);
      end else begin
        bus.i_req = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    if (!bus.o_ack) begin
      check_val({tag, "_ack_timeout"}, 0, 1, 0);
    end else begin
      s = longint'(bus.o_sin);
      c = longint'(bus.o_cos);
      check_val({tag, "_sin"}, s, e.es, 8);
      check_val({tag, "_cos"}, c, e.ec, 8);
      check_val({tag, "_norm"}, s * s + c * c, 64'd4294967296, 42949673);
      if (chk_lat) check_val({tag, "_latency"}, lat, 17, 0);
      if (hold > 0) begin
        hs = bus.o_sin;
        hc = bus.o_cos;
        unstable = 0;
        repeat (hold) begin
          @(posedge clk);
          #1;
          if (!bus.o_ack || bus.o_sin != hs || bus.o_cos != hc) unstable++;
        end
        check_val({tag, "_hold_unstable"}, unstable, 0, 0);
      end
    end
    @(negedge clk);
    bus.i_req = 1'b0;
    @(posedge clk);
    #1;
    check_val({tag, "_ack_drop"}, bus.o_ack, 0, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int spurious;
    bus.i_req   = 1'b0;
    bus.i_theta = 20'sd0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack", bus.o_ack, 0, 0);
    check_val("rst_sin", bus.o_sin, 0, 0);
    check_val("rst_cos", bus.o_cos, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("zero",     0,       0,  1'b0, 1'b1);
    do_op("pi_2",     102944,  0,  1'b0, 1'b1);
    do_op("pi_6",     34315,   0,  1'b0, 1'b0);
    do_op("neg_pi",   -205887, 0,  1'b0, 1'b0);
    do_op("pos_pi",   205887,  0,  1'b0, 1'b0);
    do_op("m3pi_4",   -154415, 0,  1'b0, 1'b0);
    do_op("hold",     50000,   50, 1'b0, 1'b0);
    do_op("toggle",   -70000,  0,  1'b1, 1'b1);
    do_op("toggle2",  180000,  0,  1'b1, 1'b1);

    // Abort mid-computation: outputs hold a nonzero result from the last op
    @(negedge clk);
    bus.i_req   = 1'b1;
    bus.i_theta = 20'sd34315;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst_n     = 1'b0;
    bus.i_req = 1'b0;
    #1;
    check_val("abort_ack", bus.o_ack, 0, 0);
    check_val("abort_sin", bus.o_sin, 0, 0);
    check_val("abort_cos", bus.o_cos, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.o_ack) spurious++;
    end
    check_val("abort_no_ack", spurious, 0, 0);

    for (int th = -205887; th <= 205887; th += 500) begin
      do_op("sweep", th, 0, 1'b0, 1'b0);
    end
    do_op("sweep_end", 205887, 0, 1'b0, 1'b0);

    check_val("sb_empty", sb.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
